// File: rtl/stageid_pkg.sv
// Shared decode helpers and the ID/EX payload type for the decode/issue stage.
package stageid_pkg;

    localparam int REG_AW   = 5;
    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Data fields are sized for the widest supported XLEN; the stage uses the low XLEN bits.
    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] rs1;
        logic [XLEN_MAX-1:0] rs2;
        logic                rd_wren;
        logic                illegal;
    } id_ex_payload_t;

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG};
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OP_BRANCH, OP_STORE, OP_REG};
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Per-register in-flight writer counters with RAW and overflow hazard detection.
// Under STAGEID_WB_BYPASS_EN a source whose only writer retires this cycle is not hazardous.
module id_scoreboard
    import stageid_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              inc_i,
    input  logic [REG_AW-1:0] inc_addr_i,
    input  logic              dec_i,
    input  logic [REG_AW-1:0] dec_addr_i,
    input  logic              rs1_chk_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic              rs2_chk_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic              rd_chk_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    output logic              hazard_o
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]               c1, c2, cr;
    logic                        busy1, busy2;

    // Check enables arrive pre-qualified (legal, non-zero), so truncating the index is safe.
    assign c1 = cnt_q[rs1_addr_i[AW-1:0]];
    assign c2 = cnt_q[rs2_addr_i[AW-1:0]];
    assign cr = cnt_q[rd_addr_i[AW-1:0]];

`ifdef STAGEID_WB_BYPASS_EN
    assign busy1 = (c1 != '0) && !(dec_i && (dec_addr_i == rs1_addr_i) && (c1 == CW'(1)));
    assign busy2 = (c2 != '0) && !(dec_i && (dec_addr_i == rs2_addr_i) && (c2 == CW'(1)));
`else
    assign busy1 = (c1 != '0);
    assign busy2 = (c2 != '0);
`endif

    assign hazard_o = (rs1_chk_i && busy1) || (rs2_chk_i && busy2) ||
                      (rd_chk_i && (cr == CW'(MAX_INFLIGHT)));

    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (inc_i && (inc_addr_i == REG_AW'(r)) && !(dec_i && (dec_addr_i == REG_AW'(r))))
                cnt_d[r] = cnt_q[r] + CW'(1);
            else if (dec_i && (dec_addr_i == REG_AW'(r)) && !(inc_i && (inc_addr_i == REG_AW'(r)))
                     && (cnt_q[r] != '0))
                cnt_d[r] = cnt_q[r] - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/stageid_issue.sv
// Decode/issue stage: register file, scoreboard-driven stall, registered ID/EX payload.
// Optional same-cycle writeback bypass is enabled with the STAGEID_WB_BYPASS_EN macro.
module stageid_issue
    import stageid_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_id_valid,
    output logic              o_id_ready,
    input  logic [31:0]       i_instr_id,
    input  logic [XLEN-1:0]   i_pc_id,
    input  logic              i_flush,
    input  logic              i_wb_rd_wren,
    input  logic [REG_AW-1:0] i_wb_rd_addr,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic              i_ex_ready,
    output logic              o_ex_valid,
    output logic [31:0]       o_ex_instr,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [XLEN-1:0]   o_ex_rs1_data,
    output logic [XLEN-1:0]   o_ex_rs2_data,
    output logic              o_ex_rd_wren,
    output logic              o_ex_illegal
);

    localparam int         AW  = $clog2(NUM_REGS);
    localparam logic [5:0] NR6 = 6'(NUM_REGS);

    logic [6:0]              opcode;
    logic [REG_AW-1:0]       rs1, rs2, rd;
    logic                    use1, use2, wr;
    logic                    ok1, ok2, okd, okwb;
    logic                    chk1, chk2, chkd, wb_ok, illegal;
    logic                    hazard, issue;
    logic [XLEN-1:0]         rs1_rf, rs2_rf, rs1_val, rs2_val;
    logic [NUM_REGS-1:0][XLEN-1:0] rf_q;
    logic                    ex_valid_q, ex_valid_d;
    id_ex_payload_t          ex_q, ex_d;

    assign opcode = i_instr_id[6:0];
    assign rd     = i_instr_id[11:7];
    assign rs1    = i_instr_id[19:15];
    assign rs2    = i_instr_id[24:20];
    assign use1   = uses_rs1(opcode);
    assign use2   = uses_rs2(opcode);
    assign wr     = writes_rd(opcode);

    assign ok1  = {1'b0, rs1} < NR6;
    assign ok2  = {1'b0, rs2} < NR6;
    assign okd  = {1'b0, rd} < NR6;
    assign okwb = {1'b0, i_wb_rd_addr} < NR6;

    // Out-of-range indices are reported as illegal and otherwise behave like x0.
    assign chk1    = use1 && ok1 && (rs1 != '0);
    assign chk2    = use2 && ok2 && (rs2 != '0);
    assign chkd    = wr && okd && (rd != '0);
    assign illegal = (use1 && !ok1) || (use2 && !ok2) || (wr && !okd);
    assign wb_ok   = i_wb_rd_wren && (i_wb_rd_addr != '0) && okwb;

    always_ff @(posedge i_clk) begin
        if (i_reset)    rf_q <= '0;
        else if (wb_ok) rf_q[i_wb_rd_addr[AW-1:0]] <= i_wb_data;
    end

    assign rs1_rf = (ok1 && (rs1 != '0)) ? rf_q[rs1[AW-1:0]] : '0;
    assign rs2_rf = (ok2 && (rs2 != '0)) ? rf_q[rs2[AW-1:0]] : '0;

`ifdef STAGEID_WB_BYPASS_EN
    assign rs1_val = (wb_ok && (i_wb_rd_addr == rs1)) ? i_wb_data : rs1_rf;
    assign rs2_val = (wb_ok && (i_wb_rd_addr == rs2)) ? i_wb_data : rs2_rf;
`else
    assign rs1_val = rs1_rf;
    assign rs2_val = rs2_rf;
`endif

    id_scoreboard #(
        .NUM_REGS    (NUM_REGS),
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_sb (
        .clk_i     (i_clk),
        .reset_i   (i_reset),
        .inc_i     (issue && chkd),
        .inc_addr_i(rd),
        .dec_i     (wb_ok),
        .dec_addr_i(i_wb_rd_addr),
        .rs1_chk_i (chk1),
        .rs1_addr_i(rs1),
        .rs2_chk_i (chk2),
        .rs2_addr_i(rs2),
        .rd_chk_i  (chkd),
        .rd_addr_i (rd),
        .hazard_o  (hazard)
    );

    assign o_id_ready = !i_reset && !hazard && (!ex_valid_q || i_ex_ready);
    assign issue      = i_id_valid && o_id_ready && !i_flush;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (!ex_valid_q || i_ex_ready) begin
            ex_valid_d = issue;
            if (issue) begin
                ex_d = '{instr:   i_instr_id,
                         pc:      XLEN_MAX'(i_pc_id),
                         rs1:     XLEN_MAX'(rs1_val),
                         rs2:     XLEN_MAX'(rs2_val),
                         rd_wren: chkd,
                         illegal: illegal};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    assign o_ex_valid    = ex_valid_q;
    assign o_ex_instr    = ex_q.instr;
    assign o_ex_pc       = ex_q.pc[XLEN-1:0];
    assign o_ex_rs1_data = ex_q.rs1[XLEN-1:0];
    assign o_ex_rs2_data = ex_q.rs2[XLEN-1:0];
    assign o_ex_rd_wren  = ex_q.rd_wren;
    assign o_ex_illegal  = ex_q.illegal;

    generate
        if (XLEN < XLEN_MAX) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^{ex_q.pc[XLEN_MAX-1:XLEN], ex_q.rs1[XLEN_MAX-1:XLEN],
                                 ex_q.rs2[XLEN_MAX-1:XLEN]};
        end
    endgenerate

endmodule

// File: tb/tb_stageid_issue.sv
// Randomized and directed check of stageid_issue against a register/pending-count model.
module tb_stageid_issue;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int MAXI = 3;
`ifdef STAGEID_WB_BYPASS_EN
    localparam int EXP_STALL = 3;
`else
    localparam int EXP_STALL = 4;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, id_valid, flush, wb_en, ex_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc, wb_data;
    logic [4:0]      wb_addr;
    logic            id_ready, ex_valid, ex_rd_wren, ex_illegal;
    logic [31:0]     ex_instr;
    logic [XLEN-1:0] ex_pc, ex_rs1, ex_rs2;

    logic            e_rst, e_valid;
    logic [31:0]     e_instr;
    logic [XLEN-1:0] e_pc;
    logic            e_ready, e_ex_valid, e_rd_wren, e_illegal;
    logic [31:0]     e_ex_instr;
    logic [XLEN-1:0] e_ex_pc, e_rs1, e_rs2;

    stageid_issue #(.XLEN(XLEN), .NUM_REGS(NR), .MAX_INFLIGHT(MAXI)) dut (
        .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid), .o_id_ready(id_ready),
        .i_instr_id(instr), .i_pc_id(pc), .i_flush(flush),
        .i_wb_rd_wren(wb_en), .i_wb_rd_addr(wb_addr), .i_wb_data(wb_data),
        .i_ex_ready(ex_ready), .o_ex_valid(ex_valid), .o_ex_instr(ex_instr), .o_ex_pc(ex_pc),
        .o_ex_rs1_data(ex_rs1), .o_ex_rs2_data(ex_rs2), .o_ex_rd_wren(ex_rd_wren),
        .o_ex_illegal(ex_illegal));

    stageid_issue #(.XLEN(XLEN), .NUM_REGS(16), .MAX_INFLIGHT(MAXI)) u_e (
        .i_clk(clk), .i_reset(e_rst), .i_id_valid(e_valid), .o_id_ready(e_ready),
        .i_instr_id(e_instr), .i_pc_id(e_pc), .i_flush(1'b0),
        .i_wb_rd_wren(1'b0), .i_wb_rd_addr(5'd0), .i_wb_data('0),
        .i_ex_ready(1'b1), .o_ex_valid(e_ex_valid), .o_ex_instr(e_ex_instr), .o_ex_pc(e_ex_pc),
        .o_ex_rs1_data(e_rs1), .o_ex_rs2_data(e_rs2), .o_ex_rd_wren(e_rd_wren),
        .o_ex_illegal(e_illegal));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rd, input int a, input int b);
        return {7'b0, 5'(b), 5'(a), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input int rd, input int a, input int imm);
        return {12'(imm), 5'(a), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_lui(input int rd, input int imm);
        return {20'(imm), 5'(rd), 7'b0110111};
    endfunction

    // Operand usage straight from the opcode table.
    function automatic bit f_wr(input logic [6:0] op);
        case (op)
            7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    function automatic bit f_r1(input logic [6:0] op);
        case (op)
            7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    function automatic bit f_r2(input logic [6:0] op);
        case (op)
            7'h63, 7'h23, 7'h33: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Model: architectural values plus number of issued-but-not-written-back writers per register.
    logic [XLEN-1:0] m_rf [32];
    int              m_cnt[32];
    bit              m_live = 1'b0;
    logic            m_valid, m_wr, m_ill;
    logic [31:0]     m_instr;
    logic [XLEN-1:0] m_pc, m_rs1, m_rs2;

    function automatic bit m_busy(input logic [4:0] a);
        if (a == 0 || int'(a) >= NR || m_cnt[a] == 0) return 1'b0;
`ifdef STAGEID_WB_BYPASS_EN
        if (wb_en && wb_addr == a && m_cnt[a] == 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        logic [6:0] op;
        logic [4:0] rd;
        bit hz;
        op = instr[6:0];
        rd = instr[11:7];
        hz = (f_r1(op) && m_busy(instr[19:15])) || (f_r2(op) && m_busy(instr[24:20])) ||
             (f_wr(op) && rd != 0 && int'(rd) < NR && m_cnt[rd] == MAXI);
        return !rst && !hz && (!m_valid || ex_ready);
    endfunction

    function automatic bit m_issue();
        return id_valid && m_ready() && !flush;
    endfunction

    function automatic logic [XLEN-1:0] m_opnd(input logic [4:0] a);
        if (a == 0 || int'(a) >= NR) return '0;
`ifdef STAGEID_WB_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return m_rf[a];
    endfunction

    function automatic int m_cnt_next(input int r);
        bit inc, dec;
        inc = m_issue() && f_wr(instr[6:0]) && int'(instr[11:7]) == r;
        dec = wb_en && int'(wb_addr) == r;
        if (inc && !dec) return m_cnt[r] + 1;
        if (dec && !inc && m_cnt[r] > 0) return m_cnt[r] - 1;
        return m_cnt[r];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_rf[r]  <= '0;
                m_cnt[r] <= 0;
            end
            m_valid <= 1'b0; m_instr <= '0; m_pc <= '0; m_rs1 <= '0; m_rs2 <= '0;
            m_wr <= 1'b0; m_ill <= 1'b0;
            m_live <= 1'b1;
        end else if (m_live) begin
            if (!m_valid || ex_ready) begin
                m_valid <= m_issue();
                if (m_issue()) begin
                    m_instr <= instr;
                    m_pc    <= pc;
                    m_rs1   <= m_opnd(instr[19:15]);
                    m_rs2   <= m_opnd(instr[24:20]);
                    m_wr    <= f_wr(instr[6:0]) && instr[11:7] != 0 && int'(instr[11:7]) < NR;
                    m_ill   <= 1'b0;
                end
            end
            for (int r = 1; r < NR; r++) m_cnt[r] <= m_cnt_next(r);
            if (wb_en && wb_addr != 0 && int'(wb_addr) < NR) m_rf[wb_addr] <= wb_data;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("ex_valid", 64'(ex_valid), 64'(m_valid));
            chk("ex_instr", 64'(ex_instr), 64'(m_instr));
            chk("ex_pc", 64'(ex_pc), 64'(m_pc));
            chk("ex_rd_wren", 64'(ex_rd_wren), 64'(m_wr));
            chk("ex_illegal", 64'(ex_illegal), 64'(m_ill));
            if (f_r1(m_instr[6:0])) chk("ex_rs1", 64'(ex_rs1), 64'(m_rs1));
            if (f_r2(m_instr[6:0])) chk("ex_rs2", 64'(ex_rs2), 64'(m_rs2));
            chk("id_ready", 64'(id_ready), 64'(m_ready()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6f; 3: op = 7'h67; 4: op = 7'h63;
            5: op = 7'h03; 6: op = 7'h23; 7: op = 7'h13; 8: op = 7'h33;
            default: op = 7'h7f;
        endcase
        r[6:0]   = op;
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  stall, start, idx;
        bit  done;
        rst = 1; id_valid = 0; instr = '0; pc = '0; flush = 0;
        wb_en = 0; wb_addr = '0; wb_data = '0; ex_ready = 1;
        e_rst = 1; e_valid = 0; e_instr = '0; e_pc = '0;
        tick; tick;
        #4 chk("rst_ready", 64'(id_ready), 64'd0);
        tick; rst = 0; e_rst = 0;
        #4 chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_ready_rel", 64'(id_ready), 64'd1);

        // RAW stall on x5; writeback arrives after three stalled cycles.
        tick; id_valid = 1; instr = enc_i(5, 0, 7); pc = 32'h100;
        #4 chk("addi_ready", 64'(id_ready), 64'd1);
        stall = 0; done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick; instr = enc_r(6, 5, 5); pc = 32'h104;
            wb_en = (k == 3); wb_addr = 5'd5; wb_data = 32'd7;
            #4;
            if (id_ready) done = 1;
            else stall++;
        end
        chk("add_issued", 64'(done), 64'd1);
        chk("stall_len", 64'(stall), 64'(EXP_STALL));
        tick; id_valid = 0; wb_en = 0;
        #4 chk("add_rs1_7", 64'(ex_rs1), 64'd7);
        chk("add_rs2_7", 64'(ex_rs2), 64'd7);
        chk("add_instr", 64'(ex_instr), 64'(enc_r(6, 5, 5)));

        // Self-dependent chain on x7 stalls after the first.
        tick; id_valid = 1; instr = enc_i(7, 7, 1);
        #4 chk("x7_first", 64'(id_ready), 64'd1);
        tick; #4 chk("x7_second", 64'(id_ready), 64'd0);
        tick; #4 chk("x7_third", 64'(id_ready), 64'd0);

        // Fourth writer of x8 waits for a retirement.
        for (int i = 0; i < 3; i++) begin
            tick; instr = enc_lui(8, i + 1);
            #4 chk("lui_issue", 64'(id_ready), 64'd1);
        end
        tick; instr = enc_lui(8, 4);
        #4 chk("lui4_stall", 64'(id_ready), 64'd0);
        tick; wb_en = 1; wb_addr = 5'd8; wb_data = 32'h55;
        #4 chk("lui4_wb_cyc", 64'(id_ready), 64'd0);
        tick; wb_en = 0;
        #4 chk("lui4_go", 64'(id_ready), 64'd1);

        // EX backpressure holds the payload.
        tick; instr = enc_r(11, 0, 0); ex_ready = 0;
        #4 chk("bp_ready0", 64'(id_ready), 64'd0);
        chk("bp_instr0", 64'(ex_instr), 64'(enc_lui(8, 4)));
        tick;
        #4 chk("bp_instr1", 64'(ex_instr), 64'(enc_lui(8, 4)));
        chk("bp_valid1", 64'(ex_valid), 64'd1);
        tick; ex_ready = 1;
        #4 chk("bp_release", 64'(id_ready), 64'd1);
        tick; id_valid = 0;
        #4 chk("bp_next", 64'(ex_instr), 64'(enc_r(11, 0, 0)));

        // Flushed instruction leaves no scoreboard trace.
        tick; id_valid = 1; instr = enc_i(9, 0, 1); flush = 1;
        tick; flush = 0; instr = enc_r(10, 9, 0);
        #4 chk("flush_bubble", 64'(ex_valid), 64'd0);
        chk("flush_no_stall", 64'(id_ready), 64'd1);
        tick; id_valid = 0;
        #4 chk("post_flush_valid", 64'(ex_valid), 64'd1);

        for (int c = 0; c < 3000; c++) begin
            tick;
            rst      = ($urandom_range(0, 499) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            instr    = rand_instr();
            pc       = $urandom;
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ex_ready && ($urandom_range(0, 9) == 0);
            wb_en    = 0;
            wb_addr  = '0;
            wb_data  = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                start = $urandom_range(1, 31);
                for (int j = 0; j < 31; j++) begin
                    idx = 1 + ((start - 1 + j) % 31);
                    if (!wb_en && m_cnt[idx] > 0) begin
                        wb_en = 1; wb_addr = 5'(idx);
                    end
                end
            end
            if (!wb_en && $urandom_range(0, 15) == 0) wb_en = 1;
        end

        // Reset with writers outstanding.
        tick; rst = 0; flush = 0; wb_en = 0; ex_ready = 1; id_valid = 1; instr = enc_lui(1, 1);
        tick; instr = enc_lui(2, 2);
        tick; instr = enc_lui(3, 3);
        tick; rst = 1; instr = enc_r(3, 1, 2);
        #4 chk("mid_rst_ready", 64'(id_ready), 64'd0);
        tick; rst = 0;
        #4 chk("mid_rst_valid", 64'(ex_valid), 64'd0);
        chk("mid_rst_go", 64'(id_ready), 64'd1);
        tick; id_valid = 0;
        #4 chk("mid_rst_issue", 64'(ex_valid), 64'd1);
        chk("mid_rst_rs1", 64'(ex_rs1), 64'd0);
        chk("mid_rst_rs2", 64'(ex_rs2), 64'd0);

        // 16-register build: out-of-range fields.
        tick; e_valid = 1; e_instr = enc_r(20, 1, 17); e_pc = 32'h200;
        #4 chk("e_ready", 64'(e_ready), 64'd1);
        tick; e_instr = enc_r(3, 1, 17);
        #4 chk("e_illegal", 64'(e_illegal), 64'd1);
        chk("e_valid", 64'(e_ex_valid), 64'd1);
        chk("e_rs2_zero", 64'(e_rs2), 64'd0);
        chk("e_rs1_zero", 64'(e_rs1), 64'd0);
        chk("e_rd_wren0", 64'(e_rd_wren), 64'd0);
        chk("e_pc", 64'(e_ex_pc), 64'h200);
        tick; e_instr = enc_r(3, 0, 0);
        #4 chk("e_illegal2", 64'(e_illegal), 64'd1);
        chk("e_rd_wren1", 64'(e_rd_wren), 64'd1);
        chk("e_instr2", 64'(e_ex_instr), 64'(enc_r(3, 1, 17)));
        tick; e_valid = 0;
        #4 chk("e_legal", 64'(e_illegal), 64'd0);

        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stageid_issue.md
Name: stageid_issue

Overview:
- Parametrised decode/issue stage for the non-forwarding in-order pipeline.
- Owns the register file and a per-register scoreboard of in-flight writers, and detects RAW and overflow hazards.
- Stalls IF with a ready handshake and drives a registered ID/EX payload with valid/ready toward EX.
- Control unit and immediate generator sit alongside in the stage wrapper, decoding the same instruction; this block handles operands and issue only.

Parameters:
- XLEN, 32, data/PC width.
- NUM_REGS, 32, architectural registers (32 = RV32I, 16 = RV32E).
- MAX_INFLIGHT, 3, max outstanding writes per register (EX, MEM, WB).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_id_valid  in  1  instruction present in ID
- o_id_ready  out  1  ID accepts/advances; low = stall IF and hold ID
- i_instr_id  in  32  instruction in ID
- i_pc_id  in  XLEN  PC of instruction in ID
- i_flush  in  1  branch/jump taken in EX; kill the ID instruction
- i_wb_rd_wren  in  1  writeback enable
- i_wb_rd_addr  in  5  writeback destination
- i_wb_data  in  XLEN  writeback data
- i_ex_ready  in  1  EX accepts the ID/EX payload
- o_ex_valid  out  1  ID/EX payload valid
- o_ex_instr  out  32  registered instruction
- o_ex_pc  out  XLEN  registered PC
- o_ex_rs1_data  out  XLEN  registered rs1 operand
- o_ex_rs2_data  out  XLEN  registered rs2 operand
- o_ex_rd_wren  out  1  issued instruction writes a non-x0 rd
- o_ex_illegal  out  1  issued instruction names a register >= NUM_REGS

Behaviour:
- Reset (sync, i_reset=1 at edge):
  - o_ex_valid=0; all o_ex_* payload = 0.
  - Register file and scoreboard counters = 0.
  - o_id_ready=0 while i_reset is high.
- Operand-use decode (opcode[6:0]):
  - rd written: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - rs1 read: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 read: BRANCH, STORE, OP.
  - Index 0 is never tracked; x0 always reads 0 and writes to it are discarded.
- Register file: NUM_REGS x XLEN; written at the clock edge when i_wb_rd_wren=1 and addr != 0; read combinationally.
- Scoreboard: one counter per register, width clog2(MAX_INFLIGHT+1).
  - Increment on issue of an rd writer.
  - Decrement on i_wb_rd_wren with a valid non-zero addr.
  - Increment and decrement on the same register in the same cycle: unchanged.
  - Decrement at 0: holds 0 (protocol violation, not flagged).
- Hazard (combinational):
  - used rs1 != 0 with cnt[rs1] != 0 and not bypassed; or
  - used rs2 != 0 with cnt[rs2] != 0 and not bypassed; or
  - rd writer with cnt[rd] == MAX_INFLIGHT.
- Handshake:
  - o_id_ready = !i_reset & !hazard & (!o_ex_valid | i_ex_ready).
  - issue = i_id_valid & o_id_ready & !i_flush.
  - ID->EX latency: 1 cycle.
- Output register:
  - If (!o_ex_valid | i_ex_ready): o_ex_valid <= issue; payload loads only on issue.
  - Otherwise everything holds.
  - When o_ex_valid=1 and i_ex_ready=0, payload is stable.
- Flush: i_flush has priority over issue. No scoreboard increment; the payload drains as a bubble. Legal only together with i_ex_ready=1.
- Illegal register (NUM_REGS=16): any used field >= NUM_REGS sets o_ex_illegal on issue.
  - That index is excluded from the hazard check and is not incremented.
  - Its operand reads as 0.
- Reset mid-operation: all in-flight scoreboard state is discarded; downstream stages are reset in the same cycle.

Optional Feature:
- Macro STAGEID_WB_BYPASS_EN.
- Defined:
  - A same-cycle WB write to a used source returns i_wb_data as that operand.
  - That source is not hazardous when cnt == 1, so the dependent instruction issues in the WB cycle.
- Undefined:
  - No bypass; the read returns the pre-write value.
  - The hazard holds until the counter reaches 0, i.e. one extra stall cycle.

Decomposition:
- Package stageid_pkg:
  - Opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG).
  - Struct id_ex_payload_t (instr, pc, rs1, rs2, rd_wren, illegal).
  - Functions uses_rs1 / uses_rs2 / writes_rd.
- One sub-module: id_scoreboard (counters, inc/dec, hazard outputs).

Test Plan:
- Reset mid-stream with 3 outstanding writes -> next cycle o_ex_valid=0, all counters 0, instruction "add x3,x1,x2" issues immediately.
- "addi x5,x0,7" then "add x6,x5,x5", no WB yet -> second stalls (o_id_ready=0) until WB of x5=7; then o_ex_rs1_data=o_ex_rs2_data=7. Stall is 3 cycles with bypass, 4 without.
- Four back-to-back "addi x7,x7,1" with no WB -> first issues; later ones stall on RAW. Separately, writes to x8 from "lui" with MAX_INFLIGHT=3 -> 4th stalls until one WB of x8.
- i_ex_ready=0 for 2 cycles with o_ex_valid=1 -> payload stable, o_id_ready=0, no counter change; i_ex_ready=1 -> next instruction loads.
- i_flush=1 with "addi x9,x0,1" valid in ID -> o_ex_valid=0 next cycle, cnt[x9] stays 0, later "add x10,x9,x0" issues without stall.
- NUM_REGS=16, "add x20,x1,x17" -> o_ex_illegal=1, o_ex_rs2_data=0, o_ex_rd_wren=0, cnt unchanged.
